// File: rtl/guess_btn_conditioner_pkg.sv
// Shared definitions for the guess-game button front end: button count,
// the button vector type and the default timing constants.
package guess_btn_conditioner_pkg;

  // Number of physical pushbuttons feeding the game.
  localparam int NUM_BTN = 4;

  // One bit per button, bit i = button i.
  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Board defaults at the nominal system clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 500_000;
  localparam int unsigned DEFAULT_EN_PERIOD       = 50_000_000;

  // Width needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? $clog2(n) : 1;
    return w;
  endfunction

endpackage

// File: rtl/guess_btn_conditioner_if.sv
// Signals between the board/game side and the button conditioner.
// Handshake: there is none beyond the en strobe. en is high for exactly one
// cycle per period; b is registered and stable for that whole cycle, so the
// consumer samples b on the clock edge that ends the en cycle.
interface guess_btn_conditioner_if;
  import guess_btn_conditioner_pkg::*;

  btn_vec_t btn_raw;    // raw pushbuttons, async, bouncy, active-high
  logic     game_over;  // while high, presses are thrown away
  btn_vec_t b;          // presses accumulated in the current period
  logic     en;         // one-cycle game step pulse
  btn_vec_t btn_level;  // debounced button levels

  // Board / game FSM side.
  modport master (
    output btn_raw,
    output game_over,
    input  b,
    input  en,
    input  btn_level
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    input  game_over,
    output b,
    output en,
    output btn_level
  );

endinterface

// File: rtl/guess_btn_conditioner_debounce.sv
// Single-button conditioner: 2-FF synchroniser, stability counter that only
// accepts a new level after DEBOUNCE_CYCLES consecutive differing samples,
// and a one-cycle press strobe on each clean rising edge of the level.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic press_o
);

  // Counter must be able to reach DEBOUNCE_CYCLES-1; one extra code of
  // headroom keeps DEBOUNCE_CYCLES=1 at a legal one-bit width.
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic          level_dly_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Stability counter: any agreement with the current level restarts it,
  // so only an unbroken run of DEBOUNCE_CYCLES differing samples flips it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Debounced level, its one-cycle-delayed copy and the counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
    end
  end

  assign level_o = level_q;
  // Rising edge of the clean level only; releases and holds give nothing.
  assign press_o = level_q & ~level_dly_q;

endmodule

// File: rtl/guess_btn_conditioner.sv
// Input front end for the guess game: debounces the four buttons, produces
// the periodic en step pulse and accumulates presses into b between pulses.
module guess_btn_conditioner
  import guess_btn_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned EN_PERIOD       = DEFAULT_EN_PERIOD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  guess_btn_conditioner_if.slave bus
);

  localparam int unsigned TW = cnt_width(EN_PERIOD);
  localparam logic [TW-1:0] TCNT_LAST = TW'(EN_PERIOD - 1);
  localparam logic [TW-1:0] TCNT_ONE  = TW'(1);

  btn_vec_t      level;
  btn_vec_t      press;
  btn_vec_t      b_q;
  btn_vec_t      b_d;
  logic          en_q;
  logic          en_d;
  logic [TW-1:0] tcnt_q;
  logic [TW-1:0] tcnt_d;

  // One conditioner per button.
  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .raw_i   (bus.btn_raw[i]),
      .level_o (level[i]),
      .press_o (press[i])
    );
  end

  // Period counter wraps at EN_PERIOD-1; en is registered so it is high
  // during the cycle after the counter lands on its last value.
  always_comb begin
    tcnt_d = (tcnt_q == TCNT_LAST) ? '0 : tcnt_q + TCNT_ONE;
    en_d   = (tcnt_d == TCNT_LAST);
  end

  // Accumulator: game over wipes everything; the edge that ends an en cycle
  // restarts from the current press so nothing landing on the tick is lost.
  always_comb begin
    b_d = b_q | press;
    if (bus.game_over) begin
      b_d = '0;
    end else if (en_q) begin
      b_d = press;
    end
  end

  // Tick counter, en strobe and guess register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt_q <= '0;
      en_q   <= 1'b0;
      b_q    <= '0;
    end else begin
      tcnt_q <= tcnt_d;
      en_q   <= en_d;
      b_q    <= b_d;
    end
  end

  assign bus.b         = b_q;
  assign bus.en        = en_q;
  assign bus.btn_level = level;

endmodule
